// File: rtl/bird_renderer.sv
// ============================================================================
// Module   : bird_renderer
// Purpose  : Paints the bird box into the 160x120 framebuffer over the x/y/
//            colour/plot write port. Each move erases the old box, then draws
//            the new one. Define BIRD_SPRITE_EN to draw an eye/beak pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_renderer #(
    parameter int         BIRD_X      = 20,
    parameter int         BIRD_W      = 4,
    parameter int         BIRD_H      = 4,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] BIRD_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR   = 3'b011
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       update,
    input  logic [6:0] new_y,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] c_bird_x  = 8'(BIRD_X);
    localparam logic [7:0] c_cx_last = 8'(BIRD_W - 1);
    localparam logic [6:0] c_cy_last = 7'(BIRD_H - 1);
    localparam logic [6:0] c_y_max   = 7'(SCREEN_H - BIRD_H);

    logic [1:0] r_state;
    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic [6:0] r_cur_y;
    logic [6:0] r_old_y;
    logic       r_first;

    logic [1:0] w_next_state;
    logic [7:0] w_next_cx;
    logic [6:0] w_next_cy;
    logic [6:0] w_next_cur_y;
    logic [6:0] w_clamped_y;
    logic       w_last_pixel;
    logic [2:0] w_draw_colour;

    assign w_clamped_y  = (new_y > c_y_max) ? c_y_max : new_y;
    assign w_last_pixel = (r_cx == c_cx_last) && (r_cy == c_cy_last);

    // Next-pixel logic: outputs are registered from these, so the pixel
    // chosen at an edge is the one presented during the following cycle.
    always_comb begin
        w_next_state = r_state;
        w_next_cx    = r_cx;
        w_next_cy    = r_cy;
        w_next_cur_y = r_cur_y;
        case (r_state)
            S_IDLE: begin
                if (update) begin
                    w_next_cur_y = w_clamped_y;
                    w_next_cx    = 8'd0;
                    w_next_cy    = 7'd0;
                    w_next_state = r_first ? S_DRAW : S_ERASE;
                end
            end
            S_ERASE, S_DRAW: begin
                if (w_last_pixel) begin
                    w_next_cx    = 8'd0;
                    w_next_cy    = 7'd0;
                    w_next_state = (r_state == S_ERASE) ? S_DRAW : S_DONE;
                end else if (r_cx == c_cx_last) begin
                    w_next_cx = 8'd0;
                    w_next_cy = r_cy + 7'd1;
                end else begin
                    w_next_cx = r_cx + 8'd1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

`ifdef BIRD_SPRITE_EN
    localparam logic [6:0] c_cy_eye      = 7'd1;
    localparam logic [6:0] c_cy_beak     = 7'(BIRD_H - 2);
    localparam logic [2:0] c_eye_colour  = 3'b000;
    localparam logic [2:0] c_beak_colour = 3'b100;

    always_comb begin
        w_draw_colour = BIRD_COLOUR;
        if (w_next_cx == c_cx_last && w_next_cy == c_cy_eye)
            w_draw_colour = c_eye_colour;
        else if (w_next_cx == c_cx_last && w_next_cy == c_cy_beak)
            w_draw_colour = c_beak_colour;
    end
`else
    assign w_draw_colour = BIRD_COLOUR;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cx    <= 8'd0;
            r_cy    <= 7'd0;
            r_cur_y <= 7'd0;
            r_old_y <= 7'd0;
            r_first <= 1'b1;
            x_out   <= 8'd0;
            y_out   <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cx    <= w_next_cx;
            r_cy    <= w_next_cy;
            r_cur_y <= w_next_cur_y;
            plot    <= (w_next_state == S_ERASE) || (w_next_state == S_DRAW);
            busy    <= (w_next_state != S_IDLE);
            done    <= (w_next_state == S_DONE);
            if (w_next_state == S_ERASE) begin
                x_out  <= c_bird_x + w_next_cx;
                y_out  <= r_old_y + w_next_cy;
                colour <= BG_COLOUR;
            end else if (w_next_state == S_DRAW) begin
                x_out  <= c_bird_x + w_next_cx;
                y_out  <= w_next_cur_y + w_next_cy;
                colour <= w_draw_colour;
            end
            if (r_state == S_DRAW && w_next_state == S_DONE) begin
                r_old_y <= r_cur_y;
                r_first <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
